// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the mod_counter event/timebase counter.
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_counter_tick_divider.sv
// Prescaler: emits one step per PRESCALE enabled cycles; restart drops partial progress.
module tick_divider
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  localparam int unsigned CntW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(PRESCALE - 1);

  logic [CntW-1:0] r_pre_cnt;
  logic            w_last;

  // With PRESCALE == 1 the counter never leaves 0, so every enabled cycle is a step.
  assign w_last = (r_pre_cnt == LastVal);
  assign step   = enable && w_last;

  // Prescale counter: advances on enabled cycles, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_pre_cnt <= '0;
    end else if (enable) begin
      r_pre_cnt <= w_last ? '0 : r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, load, wrap/saturate, tc pulse and sticky overflow.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf_flag
);

  localparam longint unsigned RangeTop = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_VAL);

  if (WIDTH < 1) begin : g_bad_width
    $error("mod_counter: WIDTH must be at least 1");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > RangeTop) begin : g_bad_max
    $error("mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic             w_restart;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic             w_event;
  logic [WIDTH-1:0] w_count_step;

  assign w_restart = clear | load;

  tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_tick_divider (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (w_restart),
    .step    (w_step)
  );

  assign w_load_val = (load_val > MaxVal) ? MaxVal : load_val;
  assign w_at_max   = (r_count == MaxVal);
  assign w_at_zero  = (r_count == '0);
  assign w_boundary = w_step && ((up == DIR_UP) ? w_at_max : w_at_zero);
  // clear and load outrank a step, so a boundary coinciding with them is not an event.
  assign w_event    = w_boundary && !w_restart;

  // Next count for a step: bounds are MaxVal and 0, never natural WIDTH-bit overflow.
  always_comb begin
    w_count_step = r_count;
    if (up == DIR_UP) begin
      if (w_at_max) begin
        w_count_step = (sat_mode == MODE_SAT) ? MaxVal : '0;
      end else begin
        w_count_step = r_count + 1'b1;
      end
    end else begin
      if (w_at_zero) begin
        w_count_step = (sat_mode == MODE_SAT) ? '0 : MaxVal;
      end else begin
        w_count_step = r_count - 1'b1;
      end
    end
  end

  // Count, tc and sticky flag registers; priority reset > clear > load > step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (clear) begin
        r_count <= '0;
        r_tc    <= 1'b0;
      end else if (load) begin
        r_count <= w_load_val;
        r_tc    <= 1'b0;
      end else begin
        r_tc <= w_event;
        if (w_step) begin
          r_count <= w_count_step;
        end
      end
      // Set beats clr_flag when both happen on the same edge.
      if (w_event) begin
        r_ovf <= 1'b1;
      end else if (clr_flag) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign count_out = r_count;
  assign tc        = r_tc;
  assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three configurations share one stimulus stream.
module tb_mod_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic       sat_mode;
  logic       clear;
  logic       load;
  logic [3:0] lv;
  logic       clr_flag;

  logic [1:0] cnt0;
  logic [3:0] cnt1;
  logic [3:0] cnt2;
  logic       tc0, tc1, tc2;
  logic       ovf0, ovf1, ovf2;

  typedef struct {
    int         sel;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  // d0: WIDTH=2, defaults
  mod_counter #(.WIDTH(2)) u_d0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(lv[1:0]), .clr_flag(clr_flag),
    .count_out(cnt0), .tc(tc0), .ovf_flag(ovf0)
  );

  // d1: decade counter, no prescale
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(lv), .clr_flag(clr_flag),
    .count_out(cnt1), .tc(tc1), .ovf_flag(ovf1)
  );

  // d2: decade counter, prescale by 3
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_d2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_val(lv), .clr_flag(clr_flag),
    .count_out(cnt2), .tc(tc2), .ovf_flag(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next
  // rising edge for the selected DUT.
  task automatic vec(input bit rst, input bit en, input bit u, input bit sat, input bit clr,
                     input bit ld, input logic [3:0] lval, input bit cf, input int sel,
                     input logic [3:0] c, input bit t, input bit o, input string nm);
    @(negedge clk);
    reset    = rst;
    enable   = en;
    up       = u;
    sat_mode = sat;
    clear    = clr;
    load     = ld;
    lv       = lval;
    clr_flag = cf;
    q.push_back('{sel: sel, cnt: c, tc: t, ovf: o, name: nm});
  endtask

  // Monitor: pops one expectation per rising edge and compares it with the selected DUT.
  initial begin
    exp_t       e;
    logic [3:0] ac;
    logic       at;
    logic       ao;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin ac = {2'b00, cnt0}; at = tc0; ao = ovf0; end
          1:       begin ac = cnt1;          at = tc1; ao = ovf1; end
          default: begin ac = cnt2;          at = tc2; ao = ovf2; end
        endcase
        n_tests = n_tests + 1;
        if (ac !== e.cnt || at !== e.tc || ao !== e.ovf) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, want count=%0d tc=%0b ovf=%0b",
                   e.name, ac, at, ao, e.cnt, e.tc, e.ovf);
        end
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    up       = 1'b1;
    sat_mode = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    lv       = 4'd0;
    clr_flag = 1'b0;

    // WIDTH=2 default range 0..3, wrap
    vec(1, 0, 1, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, "w2_reset");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 4'd1, 0, 0, "w2_c1");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 4'd2, 0, 0, "w2_c2");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 4'd3, 0, 0, "w2_c3");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 4'd0, 1, 1, "w2_wrap");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 4'd1, 0, 1, "w2_after_wrap");

    // MAX_VAL=9 wrap up, then clr_flag
    vec(1, 0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "m9_reset");
    for (int i = 1; i <= 9; i++) begin
      vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'(i), 0, 0, "m9_up");
    end
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "m9_wrap");
    vec(0, 0, 1, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "m9_clr_flag");

    // Saturating down count from 2
    vec(0, 0, 1, 0, 0, 1, 4'd2, 0, 1, 4'd2, 0, 0, "load2");
    vec(0, 1, 0, 1, 0, 0, 4'd0, 0, 1, 4'd1, 0, 0, "sat_dn1");
    vec(0, 1, 0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "sat_dn0");
    vec(0, 1, 0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "sat_hold0_a");
    vec(0, 1, 0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "sat_hold0_b");

    // PRESCALE=3 with enable pattern 1,1,0,1,1,1,1
    vec(1, 0, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "ps_reset");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "ps_en1");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "ps_en2");
    vec(0, 0, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "ps_gap");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0, "ps_en3_step");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0, "ps_en4");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0, "ps_en5");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd2, 0, 0, "ps_en6_step");

    // Load clamp and load-vs-step priority (d1 sits at 6, ovf 0)
    vec(0, 0, 1, 0, 0, 1, 4'd12, 0, 1, 4'd9, 0, 0, "load_clamp");
    vec(0, 1, 1, 0, 0, 1, 4'd9, 0, 1, 4'd9, 0, 0, "load_beats_step");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "wrap_after_load");
    vec(0, 1, 1, 0, 0, 1, 4'd3, 0, 1, 4'd3, 0, 1, "load_keeps_ovf");

    // Clear mid-prescale on the PRESCALE=3 counter
    vec(1, 0, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_reset");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_en1");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_en2");
    vec(0, 1, 1, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_clear");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_after1");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd0, 0, 0, "cl_after2");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0, "cl_after3_step");

    // Flag set-wins, single-cycle tc, reset mid-count, down wrap (d1 sits at 3)
    vec(0, 0, 1, 0, 0, 1, 4'd8, 1, 1, 4'd8, 0, 0, "load8_clr_flag");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "up_to9");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1, "set_beats_clr");
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd1, 0, 1, "tc_one_cycle");
    vec(0, 0, 1, 0, 0, 1, 4'd5, 0, 1, 4'd5, 0, 1, "load5");
    vec(1, 1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "reset_mid");
    vec(0, 1, 0, 0, 0, 0, 4'd0, 0, 1, 4'd9, 1, 1, "dn_wrap");
    vec(0, 1, 0, 0, 0, 0, 4'd0, 0, 1, 4'd8, 0, 1, "dn8");

    @(negedge clk);
    enable = 1'b0;
    // Bounded drain of the scoreboard
    for (int k = 0; k < 5 && q.size() > 0; k++) begin
      @(posedge clk);
    end
    #2;
    n_tests = n_tests + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
